// File: rtl/alu_mdu_pkg.sv
// Shared constants for the ALU/MDU block: opcodes, FSM encoding, flag bits.
// Divider presence is selected by ALU_MDU_DIV_EN in the consuming files.
package alu_mdu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int FLG_NE = 0;
  localparam int FLG_LT = 1;
  localparam int FLG_OV = 2;
  localparam int FLG_EX = 3;
  localparam int NFLG   = 4;

endpackage

// File: rtl/mdu_iter.sv
// Iterative signed shift-add multiplier and (with ALU_MDU_DIV_EN) restoring
// divider; runs on operand magnitudes and fixes the sign at the end.
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic             exc_o
);

  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

  logic               busy_q;
  logic [SHW:0]       cnt_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] sprod;

  assign a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
  assign msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
  assign prod   = {hi_q, lo_q};
  assign sprod  = neg_q ? -prod : prod;
  assign done_o = busy_q && (cnt_q == LAST);

`ifdef ALU_MDU_DIV_EN
  logic             div_q;
  logic             dz_q;
  logic             dov_q;
  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   rdiff;
  logic [WIDTH-1:0] quo;

  assign rsh   = {hi_q, lo_q[WIDTH-1]};
  assign rdiff = rsh - {1'b0, dvs_q};
  assign quo   = neg_q ? -lo_q : lo_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= 1'b0;
      dz_q  <= 1'b0;
      dov_q <= 1'b0;
    end else if (start_i) begin
      div_q <= div_i;
      dz_q  <= (b_i == '0);
      dov_q <= (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_i);
    end
  end
`else
  logic unused_div;
  assign unused_div = div_i;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      neg_q  <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      hi_q   <= '0;
      lo_q   <= a_mag;
      dvs_q  <= b_mag;
    end else if (busy_q) begin
      busy_q <= !done_o;
      cnt_q  <= cnt_q + 1'b1;
`ifdef ALU_MDU_DIV_EN
      if (div_q) begin
        hi_q <= rdiff[WIDTH] ? rsh[WIDTH-1:0] : rdiff[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], ~rdiff[WIDTH]};
      end else
`endif
      {hi_q, lo_q} <= {msum, lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    result_o = sprod[WIDTH-1:0];
    // product fits iff the top WIDTH+1 bits are a pure sign extension
    ovf_o    = ~(&sprod[2*WIDTH-1:WIDTH-1]) & (|sprod[2*WIDTH-1:WIDTH-1]);
    exc_o    = 1'b0;
`ifdef ALU_MDU_DIV_EN
    if (div_q) begin
      result_o = dz_q ? '0 : quo;
      ovf_o    = dz_q ? 1'b0 : dov_q;
      exc_o    = dz_q;
    end
`endif
  end

endmodule

// File: rtl/alu_mdu.sv
// ALU with iterative mul/div behind a valid/ready handshake.
// ALU_MDU_DIV_EN builds the divider; otherwise div is an unsupported opcode.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       ctrl_ALUopcode,
  input  logic [SHW-1:0]   ctrl_shiftamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic             overflow,
  output logic             exception
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q;
  logic [NFLG-1:0]  flg_q;
  logic             sel_q;

  logic             accept;
  logic             is_iter;
  logic             is_div;
  logic [WIDTH-1:0] sum_w, diff_w;
  logic             add_ov, sub_ov, lt, ne;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ov, alu_ex;
  logic             it_done, it_ovf, it_exc;
  logic [WIDTH-1:0] it_res;

`ifdef ALU_MDU_DIV_EN
  assign is_div = (ctrl_ALUopcode == OP_DIV);
`else
  assign is_div = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign is_iter   = (ctrl_ALUopcode == OP_MUL) || is_div;

  assign sum_w  = data_operandA + data_operandB;
  assign diff_w = data_operandA - data_operandB;
  assign add_ov = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1])
               && (sum_w[WIDTH-1] != data_operandA[WIDTH-1]);
  assign sub_ov = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1])
               && (diff_w[WIDTH-1] != data_operandA[WIDTH-1]);
  assign lt     = diff_w[WIDTH-1] ^ sub_ov;
  assign ne     = (data_operandA != data_operandB);

  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_ex  = 1'b0;
    case (ctrl_ALUopcode)
      OP_ADD: begin
        alu_res = sum_w;
        alu_ov  = add_ov;
      end
      OP_SUB: begin
        alu_res = diff_w;
        alu_ov  = sub_ov;
      end
      OP_AND: alu_res = data_operandA & data_operandB;
      OP_OR:  alu_res = data_operandA | data_operandB;
      OP_SLL: alu_res = data_operandA << ctrl_shiftamt;
      OP_SRA: alu_res = WIDTH'($signed(data_operandA) >>> ctrl_shiftamt);
      default: alu_ex = 1'b1;
    endcase
  end

  mdu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mdu (
    .clock    (clock),
    .reset    (reset),
    .start_i  (accept && is_iter),
    .div_i    (is_div),
    .a_i      (data_operandA),
    .b_i      (data_operandB),
    .done_o   (it_done),
    .result_o (it_res),
    .ovf_o    (it_ovf),
    .exc_o    (it_exc)
  );

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == S_IDLE: if (in_valid) state_d = is_iter ? S_BUSY : S_DONE;
      state_q == S_BUSY: if (it_done) state_d = S_DONE;
      state_q == S_DONE: if (out_ready) state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      flg_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q         <= is_iter;
        flg_q[FLG_NE] <= ne;
        flg_q[FLG_LT] <= lt;
        if (!is_iter) begin
          res_q         <= alu_res;
          flg_q[FLG_OV] <= alu_ov;
          flg_q[FLG_EX] <= alu_ex;
        end
      end
    end
  end

  // iterative results are read straight from the MDU, which holds them idle
  assign data_result = sel_q ? it_res : res_q;
  assign overflow    = sel_q ? it_ovf : flg_q[FLG_OV];
  assign exception   = sel_q ? it_exc : flg_q[FLG_EX];
  assign isNotEqual  = flg_q[FLG_NE];
  assign isLessThan  = flg_q[FLG_LT];

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed corner cases plus random traffic
// against an arithmetic reference model.
module tb_alu_mdu;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] r;
    logic         ne, lt, ov, ex;
    int           lat;
    int           exp_cyc;
    int           stall;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic         isNotEqual, isLessThan, overflow, exception;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic [4:0]   ctrl_ALUopcode = '0;
  logic [4:0]   ctrl_shiftamt = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t         scb[$];
  exp_t         cur;
  logic         prev_ov = 1'b0;
  logic [35:0]  held = '0;
  int           stall = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_mdu #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow),
    .exception      (exception)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(logic [4:0] op, logic [W-1:0] a,
                                 logic [W-1:0] b, logic [4:0] sh);
    exp_t   e;
    longint sa, sbv, full;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    full = 0;
    e.r = '0; e.ov = 1'b0; e.ex = 1'b0;
    e.ne = (a != b);
    e.lt = (sa < sbv);
    e.lat = 1; e.exp_cyc = 0; e.stall = 0;
    case (op)
      5'd0: begin
        full = sa + sbv;
        e.r  = full[W-1:0];
        e.ov = (full != longint'($signed(e.r)));
      end
      5'd1: begin
        full = sa - sbv;
        e.r  = full[W-1:0];
        e.ov = (full != longint'($signed(e.r)));
      end
      5'd2: e.r = a & b;
      5'd3: e.r = a | b;
      5'd4: e.r = a << sh;
      5'd5: e.r = W'($signed(a) >>> sh);
      5'd6: begin
        full  = sa * sbv;
        e.r   = full[W-1:0];
        e.ov  = (full != longint'($signed(e.r)));
        e.lat = W + 1;
      end
      5'd7: begin
`ifdef ALU_MDU_DIV_EN
        e.lat = W + 1;
        if (b == '0) e.ex = 1'b1;
        else begin
          full = sa / sbv;
          e.r  = full[W-1:0];
          e.ov = (full != longint'($signed(e.r)));
        end
`else
        e.ex = 1'b1;
`endif
      end
      default: e.ex = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return {{24{r[7]}}, r[7:0]};
      default: return r;
    endcase
  endfunction

  task automatic issue(logic [4:0] op, logic [W-1:0] a, logic [W-1:0] b,
                       logic [4:0] sh, int st);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clock);
    while (!in_ready && w < 300) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready got 0 want 1");
      return;
    end
    in_valid       = 1'b1;
    data_operandA  = a;
    data_operandB  = b;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = sh;
    e = model(op, a, b, sh);
    e.exp_cyc = cyc + e.lat;
    e.stall = st;
    scb.push_back(e);
    @(negedge clock);
    in_valid       = 1'b0;
    data_operandA  = $urandom;
    data_operandB  = $urandom;
    ctrl_ALUopcode = 5'($urandom);
    ctrl_shiftamt  = 5'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((scb.size() > 0 || !in_ready) && w < 500) begin
      @(negedge clock);
      w++;
    end
    chk("drain_pending", 64'(scb.size()), 64'd0);
  endtask

  always @(negedge clock) begin
    if (out_valid) begin
      chk("in_ready_in_done", in_ready, 1'b0);
      if (!prev_ov) begin
        checks++;
        if (scb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got out_valid data %h, want none",
                   data_result);
        end else begin
          cur = scb.pop_front();
          chk("result", data_result, cur.r);
          chk("isNotEqual", isNotEqual, cur.ne);
          chk("isLessThan", isLessThan, cur.lt);
          chk("overflow", overflow, cur.ov);
          chk("exception", exception, cur.ex);
          chk("latency_cycle", cyc, cur.exp_cyc);
          stall = cur.stall;
        end
        held = {data_result, isNotEqual, isLessThan, overflow, exception};
      end else begin
        chk("hold_stable",
            {data_result, isNotEqual, isLessThan, overflow, exception}, held);
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = 1'b1;
      end
    end else begin
      out_ready = 1'($urandom_range(0, 1));
    end
    prev_ov = out_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation got no finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs",
        {data_result, isNotEqual, isLessThan, overflow, exception}, 36'd0);
    reset = 1'b0;

    issue(5'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
    issue(5'd6, -32'sd3, 32'd7, 5'd0, 1);
    issue(5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, 0);
    issue(5'd7, -32'sd7, 32'd2, 5'd0, 0);
    issue(5'd7, 32'd5, 32'd0, 5'd0, 2);
    issue(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    issue(5'd1, 32'd3, 32'd5, 5'd0, 4);
    issue(5'b01010, 32'd9, 32'd9, 5'd0, 0);
    issue(5'd4, 32'hDEAD_BEEF, 32'd1, 5'd0, 0);
    issue(5'd5, 32'h8000_00F0, 32'd0, 5'd4, 0);
    issue(5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 0);
    issue(5'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 0);
    issue(5'd6, 32'h8000_0000, 32'h8000_0000, 5'd0, 0);
    drain();

    @(negedge clock);
    in_valid       = 1'b1;
    ctrl_ALUopcode = 5'd6;
    data_operandA  = 32'd12345;
    data_operandB  = 32'd678;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset          = 1'b1;
    in_valid       = 1'b1;
    ctrl_ALUopcode = 5'd0;
    @(negedge clock);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_outputs",
        {data_result, isNotEqual, isLessThan, overflow, exception}, 36'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (45) @(negedge clock);

    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 11));
      issue(op, rnd(), rnd(), 5'($urandom), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    drain();
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clock  input  1  single clock; all state SHALL update on rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 data_operandA, data_operandB  input  WIDTH  signed operands.
REQ-008 ctrl_ALUopcode  input  5  operation select.
REQ-009 ctrl_shiftamt  input  SHW  shift amount.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 data_result  output  WIDTH  result.
REQ-013 isNotEqual, isLessThan, overflow, exception  output  1 each  status flags, registered with data_result.

Function
REQ-014 Handshake: request accepted on edge where in_valid && in_ready; operands/opcode SHALL be captured at that edge and ignored afterward.
REQ-015 States: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Opcodes: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra, 00110 mul, 00111 div; any other code SHALL give result 0, exception=1.
REQ-017 Single-cycle ops (add..sra, unsupported): IDLE -> DONE at accept edge; out_valid SHALL rise 1 cycle after accept.
REQ-018 mul/div: IDLE -> BUSY at accept; iteration counter SHALL run WIDTH cycles; BUSY -> DONE at end; out_valid SHALL rise exactly WIDTH+1 cycles after accept.
REQ-019 DONE -> IDLE on edge where out_ready=1; outputs SHALL hold stable while out_valid && !out_ready.
REQ-020 add/sub: WIDTH-bit two's complement wrap; overflow = signed overflow of the executed op.
REQ-021 isNotEqual = (A != B); isLessThan = signed A < B (sign of A-B xor sub overflow); SHALL be valid for every opcode.
REQ-022 sll logical left, sra arithmetic right, by ctrl_shiftamt; shift of 0 returns A.
REQ-023 mul: signed; data_result = low WIDTH bits of product; overflow=1 when product not representable in WIDTH signed bits.
REQ-024 div: signed, quotient truncated toward zero; B=0 -> result 0, exception=1; A=MIN, B=-1 -> result MIN, overflow=1.
REQ-025 overflow SHALL be 0 for and, or, sll, sra; exception SHALL be 0 for all supported opcodes with legal operands.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, data_result 0, all flags 0, out_valid 0, in_ready 1 on the next edge.
REQ-027 reset in BUSY or DONE SHALL abort the operation; no out_valid for it SHALL appear afterward.
REQ-028 reset SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-029 Macro ALU_MDU_DIV_EN: defined -> iterative divider built, div per REQ-018/024.
REQ-030 Undefined -> no divider logic; div opcode SHALL behave as unsupported (result 0, exception=1, 1-cycle latency).

Structure
REQ-031 Package alu_mdu_pkg SHALL hold the opcode constants, state encoding (IDLE/BUSY/DONE) and flag-bit positions.
REQ-032 Sub-module mdu_iter SHALL implement the WIDTH-iteration shift-add multiplier and restoring divider (start, done, operands, result, flags); single-cycle ops remain in alu_mdu.

Verification (WIDTH=32)
REQ-033 add 0x7FFFFFFF + 1, out_ready=1 -> out_valid after 1 cycle, result 0x80000000, overflow=1, isLessThan=0, isNotEqual=1.
REQ-034 mul -3 * 7 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFEB, overflow=0; mul 0x10000 * 0x10000 -> result 0, overflow=1.
REQ-035 div -7 / 2 -> result -3; div 5 / 0 -> result 0, exception=1; div 0x80000000 / -1 -> 0x80000000, overflow=1; with ALU_MDU_DIV_EN undefined -> exception=1 after 1 cycle.
REQ-036 sub 3 - 5 with out_ready=0 for 4 cycles -> out_valid, result 0xFFFFFFFE, isLessThan=1 held stable; in_ready=0 until the out_ready edge.
REQ-037 reset asserted at cycle 10 of a mul -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; no late result.
REQ-038 opcode 01010 -> result 0, exception=1, overflow=0, latency 1.
